// File: rtl/video_pixel_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : video_pixel_shifter                                        |
// | Description : Video serialiser. Snoops CPU video-RAM reads, buffers the  |
// |               fetched words in a small FIFO and shifts them out as       |
// |               BPP-bit pixels, one pixel every DIV clocks.                |
// | Options     : VIDSHIFT_LSB_FIRST_EN - when defined, pixels are taken     |
// |               from the low BPP bits and the shifter moves right.         |
// |               Default build is MSB-first.                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   snoopStrobe  in   qualified video-RAM read strobe
//   snoopData    in   read data, valid LOAD_DELAY clocks after snoopStrobe
//   visible      in   1 = active display, 0 = blank/sync (flushes pipeline)
//   clrFlags     in   synchronous clear of overrun/underrun
//   pixelOut     out  current pixel (IDLE_PIX when nothing to show)
//   fifoLevel    out  number of words held in the FIFO (0..DEPTH)
//   overrun      out  sticky: word arrived while FIFO full
//   underrun     out  sticky: pixel needed while visible with no data
module video_pixel_shifter #(
  parameter int             DATA_W     = 8,
  parameter int             BPP        = 1,
  parameter int             DIV        = 2,
  parameter int             DEPTH      = 4,
  parameter int             LOAD_DELAY = 1,
  parameter logic [BPP-1:0] IDLE_PIX   = {BPP{1'b1}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   snoopStrobe,
  input  logic [DATA_W-1:0]      snoopData,
  input  logic                   visible,
  input  logic                   clrFlags,
  output logic [BPP-1:0]         pixelOut,
  output logic [$clog2(DEPTH):0] fifoLevel,
  output logic                   overrun,
  output logic                   underrun
);

  localparam int PPW   = DATA_W / BPP;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(PPW + 1);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] C_PPW      = CNT_W'(PPW);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [LVL_W-1:0] C_DEPTH    = LVL_W'(DEPTH);

`ifdef VIDSHIFT_LSB_FIRST_EN
  // Background fill enters at the top as the register moves right.
  localparam logic [DATA_W-1:0] C_FILL = DATA_W'(IDLE_PIX) << (DATA_W - BPP);
`else
  localparam logic [DATA_W-1:0] C_FILL = DATA_W'(IDLE_PIX);
`endif

  // State
  logic [LOAD_DELAY-1:0] strobe_pipe_q, strobe_pipe_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;

  // Combinational helpers
  logic              w_push_req;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_tick;
  logic              w_resync;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_overrun_evt;
  logic              w_underrun_evt;
  logic [BPP-1:0]    w_pix;
  logic [DATA_W-1:0] w_shifted;

  // Strobe delay line: aligns the strobe with the synchronous read data.
  generate
    if (LOAD_DELAY == 1) begin : g_pipe_single
      assign strobe_pipe_d = snoopStrobe;
    end else begin : g_pipe_multi
      assign strobe_pipe_d = {strobe_pipe_q[LOAD_DELAY-2:0], snoopStrobe};
    end
  endgenerate

  assign w_push_req = strobe_pipe_q[LOAD_DELAY-1];

`ifdef VIDSHIFT_LSB_FIRST_EN
  assign w_pix     = shift_q[BPP-1:0];
  assign w_shifted = (shift_q >> BPP) | C_FILL;
`else
  assign w_pix     = shift_q[DATA_W-1 -: BPP];
  assign w_shifted = (shift_q << BPP) | C_FILL;
`endif

  always_comb begin
    w_fifo_empty = (level_q == '0);
    w_fifo_full  = (level_q == C_DEPTH);
    // Divider only runs while a word is being shown; an empty shifter
    // waits at 0 so a fresh load always gets a full first pixel.
    w_tick       = (count_q != '0) && (div_q == C_DIV_LAST);
    w_resync     = (count_q == '0) && !w_fifo_empty;
    w_pop        = visible && !w_fifo_empty &&
                   (w_resync || (w_tick && (count_q == C_CNT_ONE)));
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    w_push_ok      = visible && w_push_req && (!w_fifo_full || w_pop);
    w_overrun_evt  = visible && w_push_req && w_fifo_full && !w_pop;
    w_underrun_evt = visible && w_tick && (count_q == C_CNT_ONE) && w_fifo_empty;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    shift_d    = shift_q;
    count_d    = count_q;
    div_d      = div_q;
    // Event wins over a simultaneous clear.
    overrun_d  = (overrun_q  && !clrFlags) || w_overrun_evt;
    underrun_d = (underrun_q && !clrFlags) || w_underrun_evt;

    if (!visible) begin
      // Blanking flushes everything downstream of the strobe pipe.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      count_d  = '0;
      div_d    = '0;
    end else begin
      if (w_resync) begin
        shift_d = mem_q[rd_ptr_q];
        count_d = C_PPW;
        div_d   = '0;
      end else if (count_q != '0) begin
        div_d = w_tick ? '0 : div_q + DIV_W'(1);
        if (w_tick) begin
          if (count_q > C_CNT_ONE) begin
            shift_d = w_shifted;
            count_d = count_q - C_CNT_ONE;
          end else if (!w_fifo_empty) begin
            shift_d = mem_q[rd_ptr_q];
            count_d = C_PPW;
          end else begin
            count_d = '0;
          end
        end
      end

      if (w_push_ok) begin
        mem_d[wr_ptr_q] = snoopData;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(w_push_ok) - LVL_W'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe_pipe_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      shift_q    <= '0;
      count_q    <= '0;
      div_q      <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      strobe_pipe_q <= strobe_pipe_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      div_q      <= div_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign pixelOut  = (count_q == '0) ? IDLE_PIX : w_pix;
  assign fifoLevel = level_q;
  assign overrun   = overrun_q;
  assign underrun  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_video_pixel_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_video_pixel_shifter                                     |
// | Description : Scoreboard bench for video_pixel_shifter. Three instances: |
// |               A (BPP=1, DIV=2), B (BPP=1, DIV=8), C (BPP=2, DIV=2).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_video_pixel_shifter;

  localparam int K_PIX = 0;
  localparam int K_LVL = 1;
  localparam int K_OVR = 2;
  localparam int K_UND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       strobe [3];
  logic [7:0] data   [3];
  logic       vis    [3];
  logic       clr    [3];

  logic [0:0] pix_a, pix_b;
  logic [1:0] pix_c;
  logic [2:0] lvl_a, lvl_b, lvl_c;
  logic       ovr_a, ovr_b, ovr_c;
  logic       und_a, und_b, und_c;

  video_pixel_shifter #(.DATA_W(8), .BPP(1), .DIV(2), .DEPTH(4), .LOAD_DELAY(1)) dut_a (
    .clk(clk), .reset(reset), .snoopStrobe(strobe[0]), .snoopData(data[0]),
    .visible(vis[0]), .clrFlags(clr[0]), .pixelOut(pix_a), .fifoLevel(lvl_a),
    .overrun(ovr_a), .underrun(und_a));

  video_pixel_shifter #(.DATA_W(8), .BPP(1), .DIV(8), .DEPTH(4), .LOAD_DELAY(1)) dut_b (
    .clk(clk), .reset(reset), .snoopStrobe(strobe[1]), .snoopData(data[1]),
    .visible(vis[1]), .clrFlags(clr[1]), .pixelOut(pix_b), .fifoLevel(lvl_b),
    .overrun(ovr_b), .underrun(und_b));

  video_pixel_shifter #(.DATA_W(8), .BPP(2), .DIV(2), .DEPTH(4), .LOAD_DELAY(1)) dut_c (
    .clk(clk), .reset(reset), .snoopStrobe(strobe[2]), .snoopData(data[2]),
    .visible(vis[2]), .clrFlags(clr[2]), .pixelOut(pix_c), .fifoLevel(lvl_c),
    .overrun(ovr_c), .underrun(und_c));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    dut;
    int    kind;
    int    val;
    string name;
  } exp_t;

  typedef struct {
    int         cyc;
    int         dut;
    logic [7:0] w;
  } stb_t;

  exp_t sb[$];
  stb_t sched[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int observe(input int d, input int k);
    int r;
    r = -1;
    case (d)
      0: case (k)
           K_PIX: r = int'(pix_a);
           K_LVL: r = int'(lvl_a);
           K_OVR: r = int'(ovr_a);
           default: r = int'(und_a);
         endcase
      1: case (k)
           K_PIX: r = int'(pix_b);
           K_LVL: r = int'(lvl_b);
           K_OVR: r = int'(ovr_b);
           default: r = int'(und_b);
         endcase
      default: case (k)
           K_PIX: r = int'(pix_c);
           K_LVL: r = int'(lvl_c);
           K_OVR: r = int'(ovr_c);
           default: r = int'(und_c);
         endcase
    endcase
    return r;
  endfunction

  // Monitor: pops every expectation due this cycle and compares it.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      int   act;
      e   = sb.pop_front();
      act = observe(e.dut, e.kind);
      checks++;
      if (e.cyc != cyc || act != e.val) begin
        errors++;
        $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d (due cyc %0d)",
                 e.name, e.dut, cyc, act, e.val, e.cyc);
      end
    end
  end

  // Insert keeping the scoreboard ordered by due cycle.
  task automatic expect_at(input int c, input int d, input int k, input int v, input string nm);
    exp_t e;
    int   pos;
    e.cyc = c; e.dut = d; e.kind = k; e.val = v; e.name = nm;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  // Advance one clock; strobe driven in its cycle, data one cycle later.
  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) strobe[d] = 1'b0;
    foreach (sched[i]) begin
      if (sched[i].cyc == cyc)     strobe[sched[i].dut] = 1'b1;
      if (sched[i].cyc == cyc - 1) data[sched[i].dut]   = sched[i].w;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic clear_flags(input int d);
    clr[d] = 1'b1;
    step();
    clr[d] = 1'b0;
    expect_at(cyc, d, K_OVR, 0, "clr_overrun");
    expect_at(cyc, d, K_UND, 0, "clr_underrun");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         n;
    logic [7:0] w;
    logic [15:0] w16;
    int exp_c [4];

    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      strobe[d] = 1'b0; data[d] = 8'h00; vis[d] = 1'b1; clr[d] = 1'b0;
    end
    repeat (3) step();
    reset = 1'b1;
    step();

    // Reset state
    n = cyc;
    for (int d = 0; d < 3; d++) begin
      expect_at(n, d, K_PIX, (d == 2) ? 3 : 1, "reset_pixel");
      expect_at(n, d, K_LVL, 0, "reset_level");
      expect_at(n, d, K_OVR, 0, "reset_overrun");
      expect_at(n, d, K_UND, 0, "reset_underrun");
    end
    step();

    // T1: single word A5, latency 3, each pixel held 2 clocks, then underrun
    n = cyc + 1;
    sched.push_back('{n, 0, 8'hA5});
    expect_at(n + 2, 0, K_LVL, 1, "t1_level_push");
    expect_at(n + 3, 0, K_LVL, 0, "t1_level_load");
    w = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      expect_at(n + 3 + 2*k, 0, K_PIX, int'(w[7-k]), "t1_pix");
      expect_at(n + 4 + 2*k, 0, K_PIX, int'(w[7-k]), "t1_pix_hold");
    end
    expect_at(n + 18, 0, K_UND, 0, "t1_no_underrun_yet");
    expect_at(n + 19, 0, K_PIX, 1, "t1_idle_after");
    expect_at(n + 19, 0, K_UND, 1, "t1_underrun");
    wait_until(n + 21);
    clear_flags(0);
    step();

    // T3: F0 then 0F four clocks apart -> 16 contiguous pixels
    n = cyc + 1;
    sched.push_back('{n,     0, 8'hF0});
    sched.push_back('{n + 4, 0, 8'h0F});
    expect_at(n + 2,  0, K_LVL, 1, "t3_level1");
    expect_at(n + 3,  0, K_LVL, 0, "t3_level_load");
    expect_at(n + 6,  0, K_LVL, 1, "t3_level2");
    expect_at(n + 19, 0, K_LVL, 0, "t3_level_pop2");
    w16 = 16'hF00F;
    for (int k = 0; k < 16; k++) begin
      expect_at(n + 3 + 2*k, 0, K_PIX, int'(w16[15-k]), "t3_pix");
    end
    expect_at(n + 19, 0, K_UND, 0, "t3_no_gap_underrun");
    expect_at(n + 34, 0, K_UND, 0, "t3_underrun_stays0");
    wait_until(n + 37);
    clear_flags(0);
    step();

    // T4: blank mid-word with two words queued; push on blank edge dropped
    n = cyc + 1;
    sched.push_back('{n,     0, 8'h11});
    sched.push_back('{n + 1, 0, 8'h22});
    sched.push_back('{n + 2, 0, 8'h33});
    sched.push_back('{n + 4, 0, 8'h44});
    expect_at(n + 3, 0, K_PIX, 0, "t4_pix0");
    expect_at(n + 5, 0, K_PIX, 0, "t4_pix1");
    expect_at(n + 5, 0, K_LVL, 2, "t4_level_before_blank");
    expect_at(n + 6, 0, K_LVL, 0, "t4_level_flushed");
    expect_at(n + 6, 0, K_PIX, 1, "t4_pix_blank");
    expect_at(n + 7, 0, K_LVL, 0, "t4_push_dropped");
    expect_at(n + 7, 0, K_PIX, 1, "t4_idle_after");
    expect_at(n + 8, 0, K_UND, 0, "t4_no_underrun");
    expect_at(n + 8, 0, K_OVR, 0, "t4_no_overrun");
    wait_until(n + 5);
    vis[0] = 1'b0;
    step();
    vis[0] = 1'b1;
    wait_until(n + 10);

    // T2: DIV=8, shifter busy with 00, then 01..05 back-to-back -> overrun
    n = cyc + 1;
    sched.push_back('{n, 1, 8'h00});
    for (int i = 0; i < 5; i++) sched.push_back('{n + 3 + i, 1, 8'(i + 1)});
    expect_at(n + 3, 1, K_LVL, 0, "t2_level_load");
    expect_at(n + 5, 1, K_LVL, 1, "t2_level1");
    expect_at(n + 8, 1, K_LVL, 4, "t2_level_peak");
    expect_at(n + 8, 1, K_OVR, 0, "t2_no_overrun_yet");
    expect_at(n + 9, 1, K_LVL, 4, "t2_level_full");
    expect_at(n + 9, 1, K_OVR, 1, "t2_overrun");
    expect_at(n + 67, 1, K_LVL, 3, "t2_level_after_pop");
    for (int wd = 0; wd < 5; wd++) begin
      w = 8'(wd);
      for (int k = 0; k < 8; k++) begin
        expect_at(n + 3 + 64*wd + 8*k, 1, K_PIX, int'(w[7-k]), "t2_pix");
      end
    end
    expect_at(n + 322, 1, K_UND, 0, "t2_no_underrun_yet");
    expect_at(n + 323, 1, K_UND, 1, "t2_underrun_05_dropped");
    expect_at(n + 323, 1, K_PIX, 1, "t2_idle_after");
    wait_until(n + 325);

    // T5: BPP=2, data 11_10_01_00
    n = cyc + 1;
    sched.push_back('{n, 2, 8'b11_10_01_00});
`ifdef VIDSHIFT_LSB_FIRST_EN
    exp_c = '{0, 1, 2, 3};
`else
    exp_c = '{3, 2, 1, 0};
`endif
    for (int k = 0; k < 4; k++) begin
      expect_at(n + 3 + 2*k, 2, K_PIX, exp_c[k], "t5_pix");
    end
    expect_at(n + 10, 2, K_UND, 0, "t5_no_underrun_yet");
    expect_at(n + 11, 2, K_PIX, 3, "t5_idle_after");
    expect_at(n + 11, 2, K_UND, 1, "t5_underrun");
    wait_until(n + 13);

    // T6: overrun, clear it, then async reset mid-shift
    n = cyc + 1;
    for (int i = 0; i < 6; i++) sched.push_back('{n + i, 0, 8'h00});
    expect_at(n + 6, 0, K_LVL, 4, "t6_level_full");
    expect_at(n + 6, 0, K_OVR, 0, "t6_no_overrun_yet");
    expect_at(n + 7, 0, K_OVR, 1, "t6_overrun");
    expect_at(n + 8, 0, K_OVR, 1, "t6_overrun_sticky");
    wait_until(n + 8);
    clear_flags(0);
    expect_at(cyc, 0, K_LVL, 4, "t6_level_before_reset");
    expect_at(cyc, 0, K_PIX, 0, "t6_pix_before_reset");
    step();
    reset = 1'b0;
    expect_at(cyc, 0, K_PIX, 1, "t6_reset_pixel");
    expect_at(cyc, 0, K_LVL, 0, "t6_reset_level");
    expect_at(cyc, 0, K_OVR, 0, "t6_reset_overrun");
    expect_at(cyc, 0, K_UND, 0, "t6_reset_underrun");
    expect_at(cyc, 2, K_UND, 0, "t6_reset_underrun_c");
    step();
    step();
    reset = 1'b1;
    step();
    expect_at(cyc, 0, K_PIX, 1, "t6_after_release_pixel");
    expect_at(cyc + 2, 0, K_LVL, 0, "t6_after_release_level");
    wait_until(cyc + 4);

    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
